// File: rtl/mac_perf_counter_block.sv
// Per-port Ethernet MAC statistics accumulator: a stage-1 capture register and five counters.
// Define MAC_PERF_SATURATE_EN to make the counters saturate at all-ones instead of wrapping.
module mac_perf_counter_block #(
   parameter int unsigned CTR_WIDTH = 48,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                   clk_mac,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   tx_done,
   input  logic [LEN_WIDTH-1:0]   tx_len,
   input  logic                   rx_done,
   input  logic [LEN_WIDTH-1:0]   rx_len,
   input  logic                   rx_fcs_ok,
   // {tx_frames, tx_bytes, rx_frames, rx_crc_err, rx_bytes}, tx_frames in the MSBs
   output logic [5*CTR_WIDTH-1:0] perf
);

   typedef logic [CTR_WIDTH-1:0] ctr_t;

   logic                 s1_tx_done;
   logic [LEN_WIDTH-1:0] s1_tx_len;
   logic                 s1_rx_done;
   logic [LEN_WIDTH-1:0] s1_rx_len;
   logic                 s1_rx_fcs_ok;

   ctr_t tx_frames_q, tx_frames_d;
   ctr_t tx_bytes_q, tx_bytes_d;
   ctr_t rx_frames_q, rx_frames_d;
   ctr_t rx_crc_err_q, rx_crc_err_d;
   ctr_t rx_bytes_q, rx_bytes_d;

   logic rx_good;
   logic rx_bad;
   ctr_t tx_byte_inc;
   ctr_t rx_byte_inc;

   function automatic ctr_t acc(input ctr_t base, input ctr_t inc);
`ifdef MAC_PERF_SATURATE_EN
      logic [CTR_WIDTH:0] sum;
      sum = {1'b0, base} + {1'b0, inc};
      return sum[CTR_WIDTH] ? '1 : sum[CTR_WIDTH-1:0];
`else
      return base + inc;
`endif
   endfunction

   always_ff @(posedge clk_mac or posedge reset) begin
      if (reset) begin
         s1_tx_done   <= 1'b0;
         s1_tx_len    <= '0;
         s1_rx_done   <= 1'b0;
         s1_rx_len    <= '0;
         s1_rx_fcs_ok <= 1'b0;
      end else begin
         s1_tx_done   <= tx_done;
         s1_tx_len    <= tx_len;
         s1_rx_done   <= rx_done;
         s1_rx_len    <= rx_len;
         s1_rx_fcs_ok <= rx_fcs_ok;
      end
   end

   always_comb begin
      rx_good     = s1_rx_done & s1_rx_fcs_ok;
      rx_bad      = s1_rx_done & ~s1_rx_fcs_ok;
      tx_byte_inc = s1_tx_done ? ctr_t'(s1_tx_len) : '0;
      rx_byte_inc = rx_good ? ctr_t'(s1_rx_len) : '0;
      // clear drops the old totals but still counts the event sitting in stage 1
      tx_frames_d  = acc(clear ? '0 : tx_frames_q, ctr_t'(s1_tx_done));
      tx_bytes_d   = acc(clear ? '0 : tx_bytes_q, tx_byte_inc);
      rx_frames_d  = acc(clear ? '0 : rx_frames_q, ctr_t'(rx_good));
      rx_crc_err_d = acc(clear ? '0 : rx_crc_err_q, ctr_t'(rx_bad));
      rx_bytes_d   = acc(clear ? '0 : rx_bytes_q, rx_byte_inc);
   end

   always_ff @(posedge clk_mac or posedge reset) begin
      if (reset) begin
         tx_frames_q  <= '0;
         tx_bytes_q   <= '0;
         rx_frames_q  <= '0;
         rx_crc_err_q <= '0;
         rx_bytes_q   <= '0;
      end else begin
         tx_frames_q  <= tx_frames_d;
         tx_bytes_q   <= tx_bytes_d;
         rx_frames_q  <= rx_frames_d;
         rx_crc_err_q <= rx_crc_err_d;
         rx_bytes_q   <= rx_bytes_d;
      end
   end

   assign perf = {tx_frames_q, tx_bytes_q, rx_frames_q, rx_crc_err_q, rx_bytes_q};

endmodule
